// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: bus widths, delay clamp and
// delay-line state encoding.
package fft_pkg;

  localparam int DNUM_BUS_W      = 4;
  localparam int CALC_TEMP_BUS_W = 16;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int unsigned clamp_delay(
    input int unsigned d,
    input int unsigned mx
  );
    if (d == 0) return 1;
    if (d > mx) return mx;
    return d;
  endfunction

endpackage

// File: rtl/fft_delay_ram.sv
// Circular {valid, re, im} storage with a free-running write
// pointer and a read port trailing it by len entries.
module fft_delay_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  input  logic [AW-1:0]    len,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_re,
  output logic [WIDTH-1:0] rd_im
);

  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] re_m [DEPTH];
  logic [WIDTH-1:0] im_m [DEPTH];

  // len == DEPTH truncates to 0, so the slot about to be
  // overwritten is read: exactly DEPTH cycles old.
  assign rp = wp - len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      vld <= '0;
    end else if (we) begin
      wp <= wp + 1'b1;
      if (clr) vld <= '0;
      vld[wp] <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      re_m[wp] <= in_re;
      im_m[wp] <= in_im;
    end
  end

  assign rd_valid = vld[rp];
  assign rd_re    = re_m[rp];
  assign rd_im    = im_m[rp];

endmodule

// File: rtl/fft_delay_line.sv
// Runtime-programmable complex delay line with flush on delay change.
// Optional clock enable port when FFT_DELAY_CE_EN is defined.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH     = CALC_TEMP_BUS_W,
  parameter int MAX_DEPTH = 16,
  parameter int DNUM_W    = DNUM_BUS_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FFT_DELAY_CE_EN
  input  logic              ce,
`endif
  input  logic [DNUM_W-1:0] dnum,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_re,
  input  logic [WIDTH-1:0]  in_im,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_re,
  output logic [WIDTH-1:0]  out_im,
  output logic              busy
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int LW = AW + 1;

  logic             en;
  state_e           state, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt, cnt_d;
  logic             chg, clr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_re, rd_im;

`ifdef FFT_DELAY_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  assign len_d = LW'(clamp_delay(32'(dnum), 32'(MAX_DEPTH)));
  assign chg   = (len_d != len_q);

  fft_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (en),
    .clr      (clr),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .len      (len_q[AW-1:0]),
    .rd_valid (rd_valid),
    .rd_re    (rd_re),
    .rd_im    (rd_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FLUSH;
      len_q <= LW'(1);
      cnt   <= '0;
    end else if (en) begin
      state <= state_d;
      len_q <= len_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    clr     = 1'b0;
    unique case (state)
      FLUSH: begin
        if (chg) begin
          cnt_d = '0;
          clr   = 1'b1;
        end else if (cnt == len_q - 1'b1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        if (chg) begin
          state_d = FLUSH;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == FLUSH);
  end

  // Gate on the next state so a delay change blanks output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (en) begin
      if (state_d == RUN && rd_valid) begin
        out_valid <= 1'b1;
        out_re    <= rd_re;
        out_im    <= rd_im;
      end else begin
        out_valid <= 1'b0;
        out_re    <= '0;
        out_im    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_delay_line.sv
// Random and directed stimulus against an edge-indexed history model.
// Build with FFT_DELAY_CE_EN to exercise the clock enable.
module tb_fft_delay_line;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic [4:0]  dnum = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic [15:0] out_re, out_im;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_delay_line #(
    .WIDTH     (16),
    .MAX_DEPTH (16),
    .DNUM_W    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FFT_DELAY_CE_EN
    .ce        (ce),
`endif
    .dnum      (dnum),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .busy      (busy)
  );

  // Model: every enabled edge n stores its sample in history.
  // Sample k leaves at edge k+L if k is not older than the edge
  // that last set L; reset behaves like a change at edge -1.
  logic        h_v  [8192];
  logic [15:0] h_re [8192];
  logic [15:0] h_im [8192];
  int          n, s, len;
  logic        m_ov, m_busy;
  logic [15:0] m_re, m_im;

  task automatic model_reset();
    n = 0; s = -1; len = 1;
    m_ov = 0; m_re = 0; m_im = 0; m_busy = 1;
  endtask

  task automatic model_edge();
    int lnew, k;
    lnew = (dnum == 0) ? 1 : (dnum > 16) ? 16 : int'(dnum);
    h_v[n] = in_valid; h_re[n] = in_re; h_im[n] = in_im;
    if (lnew != len) begin
      len = lnew; s = n;
      m_ov = 0; m_re = 0; m_im = 0; m_busy = 1;
    end else begin
      k = n - len;
      m_busy = !(n >= s + len);
      if (k >= s && k >= 0 && h_v[k]) begin
        m_ov = 1; m_re = h_re[k]; m_im = h_im[k];
      end else begin
        m_ov = 0; m_re = 0; m_im = 0;
      end
    end
    n++;
  endtask

  task automatic chk(input string tag, input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (ce) model_edge();
    #1;
    chk("out", {out_valid, out_re, out_im}, {m_ov, m_re, m_im});
    chk("busy", {32'd0, busy}, {32'd0, m_busy});
  endtask

  task automatic run_first();
    ce = 1; dnum = 4; in_valid = 1;
    in_re = 16'hFF4B; in_im = 16'h00B5;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i <= 4) begin
        chk("first_zero", {out_valid, out_re, out_im}, 33'd0);
        chk("first_busy", {32'd0, busy}, 33'd1);
      end else begin
        chk("first_out", {out_valid, out_re, out_im},
            {1'b1, 16'hFF4B, 16'h00B5});
        chk("first_idle", {32'd0, busy}, 33'd0);
      end
    end
  endtask

  task automatic run_rand(input int cycles, input logic [4:0] d);
    dnum = d;
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'($urandom);
      in_re = 16'($urandom); in_im = 16'($urandom);
      step();
    end
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_out", {out_valid, out_re, out_im}, 33'd0);
    chk("rst_busy", {32'd0, busy}, 33'd1);
    #9 rst_n = 1;

    run_first();

    // Ramp with bubbles on odd cycles
    dnum = 3;
    for (int i = 0; i < 60; i++) begin
      in_re = 16'(i + 1); in_im = 16'($urandom);
      in_valid = (i % 2 == 0);
      step();
    end

    run_rand(30, 5'd0);
    run_rand(20, 5'd1);
    run_rand(45, 5'd15);
    run_rand(45, 5'd31);
    run_rand(25, 5'd16);
    run_rand(20, 5'd4);
    run_rand(12, 5'd2);

    // Async reset between edges
    #2 rst_n = 0;
    #1;
    chk("arst_out", {out_valid, out_re, out_im}, 33'd0);
    chk("arst_busy", {32'd0, busy}, 33'd1);
    model_reset();
    #2 rst_n = 1;
    run_first();

`ifdef FFT_DELAY_CE_EN
    dnum = 4;
    for (int i = 0; i < 40; i++) begin
      ce = (i % 2 == 0);
      in_valid = 1'($urandom);
      in_re = 16'($urandom); in_im = 16'($urandom);
      step();
    end
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) dnum = 5'($urandom_range(0, 31));
`ifdef FFT_DELAY_CE_EN
      ce = ($urandom_range(0, 3) != 0);
`endif
      in_valid = 1'($urandom);
      in_re = 16'($urandom); in_im = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_delay_line.md
Name: fft_delay_line

Overview:
- Parametrised, runtime-programmable delay line for complex fixed-point samples in the FFT datapath.
- Used to align butterfly operands between radix-2 stages.
- Generalises the single-channel scalar delay:
  - adds complex (re/im) channels with a travelling valid bit,
  - adds async active-low reset,
  - delays up to MAX_DEPTH cycles,
  - flushes cleanly when the delay count changes at runtime.

Parameters:
- WIDTH, 16, bits per real/imag sample (signed, 8.8 fixed point at default).
- MAX_DEPTH, 16, maximum delay in cycles; power of two, at least 2.
- DNUM_W, 4, width of dnum; 2**DNUM_W >= MAX_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- dnum  in  DNUM_W  requested delay in cycles; 0 is treated as 1; values above MAX_DEPTH are clamped to MAX_DEPTH.
- in_valid  in  1  qualifies in_re/in_im.
- in_re  in  WIDTH  signed real input.
- in_im  in  WIDTH  signed imaginary input.
- out_valid  out  1  qualifies out_re/out_im.
- out_re  out  WIDTH  delayed real output.
- out_im  out  WIDTH  delayed imaginary output.
- busy  out  1  high while flushing after reset or a dnum change.

Behaviour:
- Reset, asynchronous with rst_n low:
  - out_valid, out_re, out_im = 0; busy = 1.
  - Write pointer = 0; all stored valid bits cleared; internal registered L = 1; state = FLUSH.
- Effective delay: L = clamp(dnum, 1, MAX_DEPTH). dnum is sampled every edge; a registered copy holds the active L.
- Latency: {in_valid, in_re, in_im} sampled at edge k appear on the outputs immediately after edge k+L, unchanged and bit-exact.
  - L = 1 is equivalent to a single register.
- No backpressure: one entry is written every cycle regardless of in_valid. in_valid = 0 writes a bubble, which emerges as out_valid = 0.
- out_re/out_im are driven to 0 whenever out_valid = 0, so downstream never sees stale data.
- Storage: circular buffer of MAX_DEPTH entries of {valid, re, im}.
  - Write pointer wraps MAX_DEPTH-1 -> 0.
  - Read index = (wp - L) mod MAX_DEPTH, using unsigned wrap arithmetic of log2(MAX_DEPTH) bits.
- State machine, two states:
  - FLUSH:
    - busy = 1, out_valid forced 0.
    - Fill counter counts up to L-1; on reaching it, move to RUN on the next edge.
    - New inputs are still written during FLUSH, so the first sample accepted during FLUSH emerges exactly L cycles later.
  - RUN:
    - busy = 0; outputs follow the buffer.
    - If the clamped dnum differs from the active L at an edge: load the new L, clear all stored valid bits in that same edge (data bits untouched), reset the fill counter, enter FLUSH.
- Simultaneous events:
  - A dnum change on the same edge as an in_valid sample: the sample is kept and delayed by the new L.
  - A dnum change during FLUSH restarts FLUSH with the newest L.
  - A dnum change to a value with the same clamped L (e.g. 0 -> 1) does not flush.
- Reset mid-stream discards all in-flight samples; out_valid drops asynchronously.

Optional Feature:
- Macro: FFT_DELAY_CE_EN.
- Defined:
  - Adds input port ce (1 bit), placed after rst_n.
  - ce = 0 freezes the write pointer, buffer, fill counter, state and output registers; inputs are ignored that cycle.
  - Latency is then L cycles with ce = 1.
  - Reset still acts asynchronously regardless of ce.
- Undefined: no ce port; behaviour is identical to ce tied to 1.

Decomposition:
- Shared package/header fft_pkg:
  - the DNumBus and CalcTempBus width defines reused from the FFT datapath (DNUM_W, WIDTH defaults);
  - a clamp-delay function;
  - state encodings FLUSH = 1'b0, RUN = 1'b1.
- One natural sub-module: fft_delay_ram, the circular {valid, re, im} storage with write pointer and indexed read port. The top level holds the FSM, clamp and output gating.

Test Plan:
- Reset release, dnum = 4, in_valid = 1, in_re = 16'hFF4B (-0.7071), in_im = 16'h00B5 held: busy = 1 for 4 cycles, then out_valid = 1 with out_re = FF4B, out_im = 00B5. Before that, outputs are 0.
- dnum = 3, ramp in_re = 1, 2, 3… one per cycle with in_valid = 1 on even cycles only: out_re equals in_re from 3 cycles earlier; out_valid pattern is the in_valid pattern shifted by 3 with zeroed bubbles.
- Boundaries:
  - dnum = 0 behaves as 1-cycle latency.
  - dnum = 15 gives 15-cycle latency.
  - With DNUM_W = 5, dnum = 31 clamps to 16.
  - Run at least 40 cycles to cover pointer wrap.
- Mid-stream dnum change 4 -> 2: out_valid = 0 on the next edge, busy = 1 for 2 cycles; the sample presented on the change edge emerges 2 cycles later; no pre-change sample ever appears.
- rst_n pulled low asynchronously mid-stream between edges: outputs go to 0 immediately; after release, behaves as the first scenario.
- With FFT_DELAY_CE_EN, dnum = 4, ce toggling 1, 0, 1, 0…: the sample appears after 4 ce-high cycles (8 clocks); outputs hold steady while ce = 0.
